// File: rtl/game_round_controller.sv
// Round sequencer for a whack-a-box game: lights a random box, times the hit
// window, issues score pulses and counts down the game clock.
module game_round_controller #(
  parameter int SEC_DIV   = 50_000_000,
  parameter int GAME_SECS = 60,
  parameter int WIN1      = 100_000_000,
  parameter int WIN2      = 75_000_000,
  parameter int WIN3      = 50_000_000,
  parameter int COOLDOWN  = 12_500_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] lfsr_value,
  input  logic       sensor_valid,
  input  logic [2:0] sensor_code,
  output logic [2:0] target_box,
  output logic       target_active,
  output logic       score_inc,
  output logic       score_dec,
  output logic [1:0] points,
  output logic [1:0] difficulty,
  output logic [5:0] seconds_left,
  output logic       hit_led,
  output logic       game_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_WAIT_HIT = 3'd2,
    S_HIT      = 3'd3,
    S_MISS     = 3'd4,
    S_COOLDOWN = 3'd5,
    S_OVER     = 3'd6
  } state_t;

  localparam logic [31:0] SEC_LAST  = 32'(SEC_DIV - 1);
  localparam logic [31:0] WIN1_LAST = 32'(WIN1 - 1);
  localparam logic [31:0] WIN2_LAST = 32'(WIN2 - 1);
  localparam logic [31:0] WIN3_LAST = 32'(WIN3 - 1);
  localparam logic [31:0] CD_LAST   = 32'(COOLDOWN - 1);
  localparam logic [5:0]  SECS_INIT = 6'(GAME_SECS);

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] presc;
  logic [31:0] timer;
  logic [31:0] win_load;
  logic [6:0]  elapsed;
  logic        active;
  logic        time_up;
  logic        timer_done;
  logic        strike_hit;
  logic        strike_miss;
  logic        restart;
  logic        load_target;
  logic        hit_led_nxt;

  assign state         = cur_state;
  assign active        = (cur_state == S_ARM) || (cur_state == S_WAIT_HIT) ||
                         (cur_state == S_HIT) || (cur_state == S_MISS) ||
                         (cur_state == S_COOLDOWN);
  assign time_up       = (seconds_left == 6'd0);
  assign timer_done    = (timer == 32'd0);
  assign strike_hit    = sensor_valid && (sensor_code != 3'd0) && (sensor_code == target_box);
  assign strike_miss   = sensor_valid && (sensor_code != 3'd0) && (sensor_code != target_box);
  assign elapsed       = {1'b0, SECS_INIT} - {1'b0, seconds_left};
  assign target_active = (cur_state == S_WAIT_HIT);
  assign score_inc     = (cur_state == S_HIT);
  assign score_dec     = (cur_state == S_MISS);
  assign game_over     = (cur_state == S_OVER);
  assign points        = (cur_state == S_HIT) ? difficulty : 2'd0;

  // IDLE pins the level to 1 so reset never exposes the elapsed-time view of a zero clock.
  always_comb begin
    difficulty = 2'd1;
    if (cur_state != S_IDLE) begin
      if (elapsed < 7'd20)
        difficulty = 2'd1;
      else if (elapsed < 7'd40)
        difficulty = 2'd2;
      else
        difficulty = 2'd3;
    end
  end

  always_comb begin
    win_load = WIN3_LAST;
    case (difficulty)
      2'd1:    win_load = WIN1_LAST;
      2'd2:    win_load = WIN2_LAST;
      default: win_load = WIN3_LAST;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cur_state <= S_IDLE;
    else
      cur_state <= nxt_state;
  end

  // A matching strike outranks both window expiry and the game clock running out.
  always_comb begin
    nxt_state   = cur_state;
    restart     = 1'b0;
    load_target = 1'b0;
    case (cur_state)
      S_IDLE, S_OVER: begin
        if (start) begin
          nxt_state = S_ARM;
          restart   = 1'b1;
        end
      end
      S_ARM: begin
        if (time_up)
          nxt_state = S_OVER;
        else if (lfsr_value != 3'd0) begin
          nxt_state   = S_WAIT_HIT;
          load_target = 1'b1;
        end
      end
      S_WAIT_HIT: begin
        if (strike_hit)
          nxt_state = S_HIT;
        else if (time_up)
          nxt_state = S_OVER;
        else if (strike_miss || timer_done)
          nxt_state = S_MISS;
      end
      S_HIT, S_MISS: begin
        nxt_state = time_up ? S_OVER : S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (time_up)
          nxt_state = S_OVER;
        else if (timer_done)
          nxt_state = S_ARM;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign hit_led_nxt = (nxt_state == S_HIT) || ((nxt_state == S_COOLDOWN) && hit_led);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      hit_led <= 1'b0;
    else
      hit_led <= hit_led_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      target_box <= 3'd0;
    else if (load_target)
      target_box <= lfsr_value;
  end

  // One down-counter serves both the hit window and the inter-round cooldown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      timer <= 32'd0;
    else if (load_target)
      timer <= win_load;
    else if ((cur_state == S_HIT) || (cur_state == S_MISS))
      timer <= CD_LAST;
    else if (((cur_state == S_WAIT_HIT) || (cur_state == S_COOLDOWN)) && !timer_done)
      timer <= timer - 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc        <= 32'd0;
      seconds_left <= 6'd0;
    end else if (restart) begin
      presc        <= 32'd0;
      seconds_left <= SECS_INIT;
    end else if (active) begin
      if (presc == SEC_LAST) begin
        presc <= 32'd0;
        if (!time_up)
          seconds_left <= seconds_left - 6'd1;
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller; score pulses are checked against a
// queue of expected events filled when strikes are driven.
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [2:0] lfsr_value;
  logic       sensor_valid;
  logic [2:0] sensor_code;
  logic [2:0] target_box;
  logic       target_active;
  logic       score_inc;
  logic       score_dec;
  logic [1:0] points;
  logic [1:0] difficulty;
  logic [5:0] seconds_left;
  logic       hit_led;
  logic       game_over;
  logic [2:0] state;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;
  int active_cycles;
  bit sb_enable = 1'b0;

  // Expected score events: {score_inc, score_dec, points}
  logic [3:0] exp_q[$];

  localparam logic [3:0] EV_HIT1 = 4'b1001;
  localparam logic [3:0] EV_MISS = 4'b0100;

  game_round_controller #(
    .SEC_DIV(4), .GAME_SECS(60), .WIN1(8), .WIN2(6), .WIN3(4), .COOLDOWN(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .lfsr_value(lfsr_value),
    .sensor_valid(sensor_valid), .sensor_code(sensor_code),
    .target_box(target_box), .target_active(target_active),
    .score_inc(score_inc), .score_dec(score_dec), .points(points),
    .difficulty(difficulty), .seconds_left(seconds_left), .hit_led(hit_led),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] lfsr, input logic sv, input logic [2:0] sc);
    start        = s;
    lfsr_value   = lfsr;
    sensor_valid = sv;
    sensor_code  = sc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitState(input logic [2:0] want, input int budget, input string tag);
    for (int i = 0; i < budget && state !== want; i++) tick();
    checkOutput(tag, {29'd0, state}, {29'd0, want});
  endtask

  // Every score pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : score_monitor
    logic [3:0] ev;
    if (sb_enable && resetn === 1'b1 && (score_inc === 1'b1 || score_dec === 1'b1)) begin
      checkOutput("pulse_exclusive", {31'd0, score_inc & score_dec}, 32'd0);
      if (exp_q.size() == 0)
        checkOutput("unexpected_pulse", {28'd0, score_inc, score_dec, points}, 32'd0);
      else begin
        ev = exp_q.pop_front();
        checkOutput("score_event", {28'd0, score_inc, score_dec, points}, {28'd0, ev});
      end
    end
  end

  initial begin
    sb_enable = 1'b1;
    resetn = 1'b0;
    applyStimulus(0, 3'd0, 0, 3'd0);
    tick(); tick();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_target_box", target_box, 0);
    checkOutput("rst_target_active", target_active, 0);
    checkOutput("rst_score_inc", score_inc, 0);
    checkOutput("rst_score_dec", score_dec, 0);
    checkOutput("rst_points", points, 0);
    checkOutput("rst_difficulty", difficulty, 1);
    checkOutput("rst_seconds", seconds_left, 0);
    checkOutput("rst_hit_led", hit_led, 0);
    checkOutput("rst_game_over", game_over, 0);
    resetn = 1'b1;
    tick(); tick(); tick();
    checkOutput("idle_hold", state, 0);

    // Hit on the third window cycle
    applyStimulus(1, 3'd5, 0, 3'd0);
    tick();
    applyStimulus(0, 3'd5, 0, 3'd0);
    checkOutput("arm_after_start", state, 1);
    checkOutput("start_seconds", seconds_left, 60);
    tick();
    checkOutput("wait_state", state, 2);
    checkOutput("wait_target", target_box, 5);
    checkOutput("wait_active", target_active, 1);
    tick(); tick();
    exp_q.push_back(EV_HIT1);
    applyStimulus(0, 3'd5, 1, 3'd5);
    tick();
    applyStimulus(0, 3'd5, 0, 3'd0);
    checkOutput("hit_state", state, 3);
    checkOutput("hit_inc", score_inc, 1);
    checkOutput("hit_points", points, 1);
    checkOutput("hit_led_on", hit_led, 1);
    tick();
    checkOutput("cd1_state", state, 5);
    checkOutput("cd1_led", hit_led, 1);
    tick();
    checkOutput("cd2_state", state, 5);
    checkOutput("cd2_led", hit_led, 1);
    tick();
    checkOutput("cd_to_arm", state, 1);
    checkOutput("led_cleared", hit_led, 0);

    // No strike: full window then a single miss pulse
    exp_q.push_back(EV_MISS);
    active_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (target_active === 1'b1) active_cycles++;
      if (score_dec === 1'b1) break;
    end
    checkOutput("window_len", active_cycles, 8);
    checkOutput("miss_state", state, 4);
    checkOutput("miss_led", hit_led, 0);
    tick();
    checkOutput("dec_one_cycle", score_dec, 0);

    // Code 0 ignored, wrong code misses
    waitState(3'd1, 10, "to_arm_a");
    tick();
    checkOutput("wait_b", state, 2);
    applyStimulus(0, 3'd5, 1, 3'd0);
    tick();
    checkOutput("code0_ignored", state, 2);
    exp_q.push_back(EV_MISS);
    applyStimulus(0, 3'd5, 1, 3'd3);
    tick();
    applyStimulus(0, 3'd5, 0, 3'd0);
    checkOutput("wrong_code_miss", state, 4);
    checkOutput("wrong_code_dec", score_dec, 1);

    // Matching strike on the last window cycle beats expiry
    waitState(3'd1, 10, "to_arm_b");
    tick();
    repeat (7) tick();
    checkOutput("last_cycle_active", target_active, 1);
    exp_q.push_back(EV_HIT1);
    applyStimulus(0, 3'd5, 1, 3'd5);
    tick();
    applyStimulus(0, 3'd0, 0, 3'd0);
    checkOutput("late_hit_state", state, 3);
    checkOutput("late_hit_inc", score_inc, 1);

    // Zero LFSR holds ARM
    waitState(3'd1, 10, "to_arm_c");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("arm_hold_state", state, 1);
      checkOutput("arm_hold_active", target_active, 0);
    end
    applyStimulus(0, 3'd2, 0, 3'd0);
    tick();
    checkOutput("lfsr2_state", state, 2);
    checkOutput("lfsr2_target", target_box, 2);
    applyStimulus(1, 3'd2, 0, 3'd0);
    tick();
    applyStimulus(0, 3'd2, 0, 3'd0);
    checkOutput("start_ignored", state, 2);

    // Reset in WAIT_HIT
    resetn = 1'b0;
    #1;
    checkOutput("rstw_state", state, 0);
    checkOutput("rstw_target_box", target_box, 0);
    checkOutput("rstw_active", target_active, 0);
    checkOutput("rstw_seconds", seconds_left, 0);
    checkOutput("rstw_difficulty", difficulty, 1);
    tick();
    resetn = 1'b1;
    repeat (4) tick();
    checkOutput("rstw_idle_after", state, 0);

    // Reset in HIT
    applyStimulus(1, 3'd3, 0, 3'd0);
    tick();
    applyStimulus(0, 3'd3, 0, 3'd0);
    tick();
    checkOutput("rsth_wait", state, 2);
    applyStimulus(0, 3'd3, 1, 3'd3);
    tick();
    applyStimulus(0, 3'd0, 0, 3'd0);
    checkOutput("rsth_hit", state, 3);
    resetn = 1'b0;
    #1;
    checkOutput("rsth_state", state, 0);
    checkOutput("rsth_inc", score_inc, 0);
    checkOutput("rsth_points", points, 0);
    checkOutput("rsth_led", hit_led, 0);
    tick();
    resetn = 1'b1;
    repeat (4) tick();
    checkOutput("rsth_idle_after", state, 0);
    checkOutput("rsth_no_inc", score_inc, 0);

    // Free run to game over
    sb_enable = 1'b0;
    applyStimulus(1, 3'd6, 0, 3'd0);
    tick();
    applyStimulus(0, 3'd6, 0, 3'd0);
    checkOutput("run_seconds0", seconds_left, 60);
    repeat (79) tick();
    checkOutput("run_secs_79", seconds_left, 41);
    checkOutput("run_diff_79", difficulty, 1);
    tick();
    checkOutput("run_secs_80", seconds_left, 40);
    checkOutput("run_diff_80", difficulty, 2);
    repeat (79) tick();
    checkOutput("run_secs_159", seconds_left, 21);
    checkOutput("run_diff_159", difficulty, 2);
    tick();
    checkOutput("run_secs_160", seconds_left, 20);
    checkOutput("run_diff_160", difficulty, 3);
    repeat (80) tick();
    checkOutput("run_secs_240", seconds_left, 0);
    waitState(3'd6, 10, "to_over");
    checkOutput("over_flag", game_over, 1);
    checkOutput("over_active", target_active, 0);
    checkOutput("over_led", hit_led, 0);
    checkOutput("over_target_hold", target_box, 6);
    sb_enable = 1'b1;
    applyStimulus(1, 3'd0, 0, 3'd0);
    tick();
    applyStimulus(0, 3'd0, 0, 3'd0);
    checkOutput("restart_state", state, 1);
    checkOutput("restart_seconds", seconds_left, 60);
    checkOutput("restart_game_over", game_over, 0);
    tick();
    checkOutput("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
